elevator_request_scheduler: RTL
===============================

# elevator_request_scheduler

- Sequences a 4-floor elevator car.
- Latches floor requests into a pending set and chooses travel direction with a SCAN policy: keep going while requests lie ahead, then reverse.
- Times floor-to-floor travel and door dwell, and holds the door open on overload.
- Sits above the car/door drive logic and produces the same status outputs the elevator controller exposes to the rest of the design.

## Interface
- `TRAVEL_CYCLES`, 4: clock cycles per one-floor move (≥2).
- `DOOR_CYCLES`, 6: clock cycles the door stays open (≥2).
- `WEIGHT_LIMIT`, 150: load above which the car is overloaded.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `floor_request`  in  4  per-floor request bits (bit i = floor i); level or pulse, sampled every cycle.
- `weight`  in  8  car load, unsigned.
- `current_floor`  out  2  floor the car is at or last passed.
- `moving_up`  out  1  car travelling up.
- `moving_down`  out  1  car travelling down.
- `door_open`  out  1  door open.
- `overload`  out  1  registered `weight > WEIGHT_LIMIT`.
- `pending`  out  4  outstanding requests.

## Operation
- States: IDLE, MOVE_UP, MOVE_DOWN, DOOR.
- Direction register `dir`: up/down, reset up.
- `pending` update, every edge: `pending <= (pending | floor_request) & ~clear`. `clear` is the one-hot bit of the floor being serviced. Clear wins over a same-cycle request for that floor.
- IDLE, priority order:
  - `pending[current_floor]` set: go to DOOR, clear that bit.
  - Any pending bit ahead in `dir`: go to MOVE in `dir`.
  - Any pending bit behind: flip `dir` and go to MOVE in the new direction.
  - Otherwise stay in IDLE.
- MOVE_x:
  - Travel counter runs 0..TRAVEL_CYCLES-1.
  - On the edge where it reaches TRAVEL_CYCLES-1, `current_floor` steps ±1 and the counter resets.
  - At that same edge, if the new floor is pending: go to DOOR and clear the bit.
  - Else, if requests remain further in `dir`: stay in MOVE.
  - Else: go to IDLE.
- DOOR:
  - Dwell counter runs 0..DOOR_CYCLES-1; exit to IDLE when it expires.
  - If `overload` is 1, the counter is held at 0 and the door stays open.
  - A request for `current_floor` arriving in DOOR restarts the dwell counter at 0 and is not latched.
- Outputs:
  - `moving_up` = state MOVE_UP; `moving_down` = state MOVE_DOWN; `door_open` = state DOOR. All are registered state decodes.
  - `moving_up` and `moving_down` are never both 1. `door_open` never coincides with either.
- Floor 3 never moves up and floor 0 never moves down. Bits ahead of the top or bottom floor do not exist, so no wrap-around is possible.
- A request for the floor just departed during MOVE stays pending and is served after reversal.

## Timing
- Reset values: state IDLE, `current_floor`=0, `dir`=up, `pending`=0, all counters 0, and every output 0.
- Reset is asynchronous. Asserting it mid-travel or with the door open returns immediately to these values. The floor reverts to 0, modelling home calibration.
- All outputs are registered; there are no combinational input-to-output paths.
- Request at the idle car's floor: request seen at edge t → `pending` bit at t+1 → `door_open`=1 from edge t+2. The bit is cleared at the same edge.
- Travel: MOVE entered at edge s → floor changes at edge s+TRAVEL_CYCLES. A move of k floors takes k·TRAVEL_CYCLES cycles of `moving_*`=1.
- Door: `door_open` high for exactly DOOR_CYCLES cycles without overload, then IDLE for at least one cycle.
- `overload` lags `weight` by one cycle.

## Structure
- `elevator_pkg`:
  - `state_t` enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR).
  - `NUM_FLOORS`=4, `FLOOR_W`=2.
  - `dir_t` (UP, DOWN).
- Sub-module `elevator_request_reg`:
  - Holds the `pending` register with its set/clear logic.
  - Provides `any_above`/`any_below` reductions relative to `current_floor`.
- The top level holds the FSM, both counters and the output registers.

## Test plan
- Reset → all outputs 0, floor 0. Pulse `floor_request`=0001 at edge t → `door_open`=1 for cycles t+2..t+7, then IDLE with `pending`=0.
- At floor 0, request 0100 → `moving_up`=1 for 8 cycles, `current_floor` reads 1 then 2, then `door_open`=1 at floor 2 and bit 2 is cleared.
- At floor 1 moving up, with 1000 and 0001 both pending → serves floor 3 first, reverses, and stops at floor 0. `moving_up` and `moving_down` are never both 1.
- Door open, `weight`=200 → `overload`=1 one cycle later and the door stays open indefinitely. `weight`=100 → the door closes DOOR_CYCLES cycles after `overload` falls.
- Request for `current_floor` during DOOR → the dwell restarts and `pending` is unchanged. Request 0001 exactly on the clear edge of floor 0 → not re-latched.
- `rst_n` pulsed low mid-travel between floors 1 and 2 → outputs go 0 immediately. After release, the car is at floor 0, idle, with `pending`=0.

Source files
------------

// File: rtl/elevator_pkg.sv
// ---------------------------------------------------------------------------
// elevator_pkg
// Shared types and constants for the elevator request scheduler slice.
//   state_t      : scheduler FSM states (IDLE, MOVE_UP, MOVE_DOWN, DOOR)
//   dir_t        : SCAN travel direction (UP, DOWN)
//   NUM_FLOORS   : number of served floors (4)
//   FLOOR_W      : width of a floor index (2)
//   floor_onehot : one-hot mask for a floor index
// ---------------------------------------------------------------------------
package elevator_pkg;

   localparam int NUM_FLOORS = 4;
   localparam int FLOOR_W    = 2;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      MOVE_UP   = 2'd1,
      MOVE_DOWN = 2'd2,
      DOOR      = 2'd3
   } state_t;

   typedef enum logic {
      UP   = 1'b0,
      DOWN = 1'b1
   } dir_t;

   function automatic logic [NUM_FLOORS-1:0] floor_onehot(input logic [FLOOR_W-1:0] f);
      logic [NUM_FLOORS-1:0] m;
      m    = '0;
      m[f] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/elevator_request_reg.sv
// ---------------------------------------------------------------------------
// elevator_request_reg
// Holds the set of outstanding floor requests and reports whether any of
// them lie above or below the car.
//   clk, rst_n     : clock, asynchronous active-low reset
//   floor_request  : per-floor request bits, OR-ed into the set every cycle
//   clear          : one-hot floor being serviced; wins over a same-cycle set
//   current_floor  : car position used for the above/below reductions
//   pending        : registered outstanding request set
//   any_above      : some pending floor is strictly above current_floor
//   any_below      : some pending floor is strictly below current_floor
// ---------------------------------------------------------------------------
module elevator_request_reg
   import elevator_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_FLOORS-1:0] floor_request,
   input  logic [NUM_FLOORS-1:0] clear,
   input  logic [FLOOR_W-1:0]    current_floor,
   output logic [NUM_FLOORS-1:0] pending,
   output logic                  any_above,
   output logic                  any_below
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
      end else begin
         pending <= (pending | floor_request) & ~clear;
      end
   end

   // Floors outside 0..NUM_FLOORS-1 do not exist, so the reductions can
   // never see a wrapped-around request.
   always_comb begin
      any_above = 1'b0;
      any_below = 1'b0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (pending[i] && (i > int'(current_floor))) any_above = 1'b1;
         if (pending[i] && (i < int'(current_floor))) any_below = 1'b1;
      end
   end

endmodule

// File: rtl/elevator_request_scheduler.sv
// ---------------------------------------------------------------------------
// elevator_request_scheduler
// SCAN scheduler for a 4-floor car: latches requests, keeps travelling while
// requests lie ahead, reverses otherwise, times floor-to-floor travel and
// door dwell, and holds the door while the car is overloaded.
//   TRAVEL_CYCLES : clock cycles per one-floor move (>= 2)
//   DOOR_CYCLES   : clock cycles the door stays open (>= 2)
//   WEIGHT_LIMIT  : load above which the car is overloaded
//   clk, rst_n    : clock, asynchronous active-low reset
//   floor_request : per-floor request bits (level or pulse)
//   weight        : car load, unsigned
//   current_floor : floor the car is at or last passed
//   moving_up     : registered decode of MOVE_UP
//   moving_down   : registered decode of MOVE_DOWN
//   door_open     : registered decode of DOOR
//   overload      : registered weight > WEIGHT_LIMIT
//   pending       : outstanding requests
// ---------------------------------------------------------------------------
module elevator_request_scheduler
   import elevator_pkg::*;
#(
   parameter int TRAVEL_CYCLES = 4,
   parameter int DOOR_CYCLES   = 6,
   parameter int WEIGHT_LIMIT  = 150
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_FLOORS-1:0] floor_request,
   input  logic [7:0]            weight,
   output logic [FLOOR_W-1:0]    current_floor,
   output logic                  moving_up,
   output logic                  moving_down,
   output logic                  door_open,
   output logic                  overload,
   output logic [NUM_FLOORS-1:0] pending
);

   localparam int TRAVEL_W = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
   localparam int DOOR_W   = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

   localparam logic [TRAVEL_W-1:0] TRAVEL_LAST = TRAVEL_W'(TRAVEL_CYCLES - 1);
   localparam logic [DOOR_W-1:0]   DOOR_LAST   = DOOR_W'(DOOR_CYCLES - 1);
   localparam logic [7:0]          WEIGHT_MAX  = 8'(WEIGHT_LIMIT);

   state_t                state;
   dir_t                  dir;
   logic [TRAVEL_W-1:0]   travel_cnt;
   logic [DOOR_W-1:0]     dwell_cnt;

   logic                  any_above;
   logic                  any_below;
   logic                  ahead;
   logic                  behind;
   logic                  moving;
   logic                  travel_done;
   logic [FLOOR_W-1:0]    next_floor;
   logic                  idle_stop;
   logic                  arrive_stop;
   logic [NUM_FLOORS-1:0] clear;

   assign ahead       = (dir == UP) ? any_above : any_below;
   assign behind      = (dir == UP) ? any_below : any_above;
   assign moving      = (state == MOVE_UP) || (state == MOVE_DOWN);
   assign travel_done = (travel_cnt == TRAVEL_LAST);
   // Only meaningful while moving; the MOVE states never start at an edge floor
   // heading outward, so the +/-1 cannot wrap when it is used.
   assign next_floor  = (state == MOVE_UP) ? current_floor + FLOOR_W'(1)
                                           : current_floor - FLOOR_W'(1);
   assign idle_stop   = (state == IDLE) && pending[current_floor];
   assign arrive_stop = moving && travel_done && pending[next_floor];

   // While the door is open the current floor's bit is continuously cleared,
   // so a request for this floor restarts the dwell instead of being latched.
   always_comb begin
      clear = '0;
      if ((state == DOOR) || idle_stop) clear = floor_onehot(current_floor);
      else if (arrive_stop)             clear = floor_onehot(next_floor);
   end

   elevator_request_reg u_request_reg (
      .clk           (clk),
      .rst_n         (rst_n),
      .floor_request (floor_request),
      .clear         (clear),
      .current_floor (current_floor),
      .pending       (pending),
      .any_above     (any_above),
      .any_below     (any_below)
   );

   // The status outputs are written alongside the state they decode so they
   // always equal the registered state without a combinational decode.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         dir           <= UP;
         current_floor <= '0;
         travel_cnt    <= '0;
         dwell_cnt     <= '0;
         moving_up     <= 1'b0;
         moving_down   <= 1'b0;
         door_open     <= 1'b0;
         overload      <= 1'b0;
      end else begin
         overload    <= (weight > WEIGHT_MAX);
         moving_up   <= 1'b0;
         moving_down <= 1'b0;
         door_open   <= 1'b0;

         case (state)
            IDLE: begin
               travel_cnt <= '0;
               dwell_cnt  <= '0;
               if (idle_stop) begin
                  state     <= DOOR;
                  door_open <= 1'b1;
               end else if (ahead) begin
                  if (dir == UP) begin
                     state     <= MOVE_UP;
                     moving_up <= 1'b1;
                  end else begin
                     state       <= MOVE_DOWN;
                     moving_down <= 1'b1;
                  end
               end else if (behind) begin
                  if (dir == UP) begin
                     dir         <= DOWN;
                     state       <= MOVE_DOWN;
                     moving_down <= 1'b1;
                  end else begin
                     dir       <= UP;
                     state     <= MOVE_UP;
                     moving_up <= 1'b1;
                  end
               end
            end

            MOVE_UP, MOVE_DOWN: begin
               if (travel_done) begin
                  travel_cnt    <= '0;
                  current_floor <= next_floor;
                  if (pending[next_floor]) begin
                     state     <= DOOR;
                     dwell_cnt <= '0;
                     door_open <= 1'b1;
                  end else if (ahead) begin
                     // next_floor is not pending, so "ahead of the old floor"
                     // equals "further beyond the new floor".
                     moving_up   <= (state == MOVE_UP);
                     moving_down <= (state == MOVE_DOWN);
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  travel_cnt  <= travel_cnt + TRAVEL_W'(1);
                  moving_up   <= (state == MOVE_UP);
                  moving_down <= (state == MOVE_DOWN);
               end
            end

            DOOR: begin
               if (overload || floor_request[current_floor]) begin
                  dwell_cnt <= '0;
                  door_open <= 1'b1;
               end else if (dwell_cnt == DOOR_LAST) begin
                  dwell_cnt <= '0;
                  state     <= IDLE;
               end else begin
                  dwell_cnt <= dwell_cnt + DOOR_W'(1);
                  door_open <= 1'b1;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
